// File: rtl/regfile_pkg.sv
// Shared definitions for the debug-capable register file.
//   - default width constants used by the interface and the top level
//   - dump_state_e: state encoding of the sequential dump engine
package regfile_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_REG_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/register_file_dbg_if.sv
// Bus bundle between the ID stage / debug unit and the register file.
//   Pipeline side : two read addresses with combinational read data,
//                   one write port (address, data, enable).
//   Debug side    : dump start request, valid/ready beat handshake carrying
//                   index and data, one-cycle done pulse, busy flag.
// master modport is the user (pipeline + debug unit), slave is the register file.
interface register_file_dbg_if
  import regfile_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_REG  = NB_REG_DEF
);

  logic [NB_REG-1:0]  i_read_reg1;
  logic [NB_REG-1:0]  i_read_reg2;
  logic [NB_REG-1:0]  i_write_reg;
  logic [NB_DATA-1:0] i_write_data;
  logic               i_write_enable;
  logic [NB_DATA-1:0] o_register1;
  logic [NB_DATA-1:0] o_register2;

  logic               i_dump_start;
  logic               i_dump_ready;
  logic               o_dump_valid;
  logic [NB_REG-1:0]  o_dump_idx;
  logic [NB_DATA-1:0] o_dump_data;
  logic               o_dump_done;
  logic               o_busy;

  modport master (
    output i_read_reg1, i_read_reg2, i_write_reg, i_write_data, i_write_enable,
    output i_dump_start, i_dump_ready,
    input  o_register1, o_register2,
    input  o_dump_valid, o_dump_idx, o_dump_data, o_dump_done, o_busy
  );

  modport slave (
    input  i_read_reg1, i_read_reg2, i_write_reg, i_write_data, i_write_enable,
    input  i_dump_start, i_dump_ready,
    output o_register1, o_register2,
    output o_dump_valid, o_dump_idx, o_dump_data, o_dump_done, o_busy
  );

endinterface

// File: rtl/register_dump_ctrl.sv
// Dump sequencer: walks the register index from 0 to NREGS-1, one beat per
// valid/ready handshake, then pulses done for one cycle and returns to IDLE.
// Ports:
//   i_clk, i_reset              clock, asynchronous active-high reset
//   i_dump_start                start request, honoured only in IDLE
//   i_dump_ready                consumer accepts the current beat
//   o_dump_valid, o_dump_idx    current beat and the register it refers to
//   o_dump_done                 one-cycle pulse after the last beat
//   o_busy                      high while beats are being offered
// All outputs decode the state register directly, so an asynchronous reset
// drops them without waiting for a clock edge.
module register_dump_ctrl
  import regfile_pkg::*;
#(
  parameter int NB_REG = NB_REG_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dump_start,
  input  logic              i_dump_ready,
  output logic              o_dump_valid,
  output logic              o_dump_done,
  output logic              o_busy,
  output logic [NB_REG-1:0] o_dump_idx
);

  localparam logic [NB_REG-1:0] LAST_IDX = '1;

  dump_state_e       state_q, state_d;
  logic [NB_REG-1:0] idx_q, idx_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    o_dump_valid = 1'b0;
    o_dump_done  = 1'b0;
    o_busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          state_d = DUMP;
          idx_d   = '0;
        end
      end
      DUMP: begin
        o_dump_valid = 1'b1;
        o_busy       = 1'b1;
        if (i_dump_ready) begin
          // The last beat leaves DUMP instead of wrapping the index.
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        o_dump_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dump_idx = idx_q;

endmodule

// File: rtl/register_file_dbg.sv
// ID-stage register file with a debug dump port.
//   - two combinational read ports with optional write-to-read bypass
//   - one write port, register 0 optionally hardwired to zero
//   - register_dump_ctrl sequences a full-array dump; this level muxes the
//     stored data for the current dump index (no bypass on that path)
// Ports:
//   i_clk, i_reset   clock, asynchronous active-high reset
//   bus              register_file_dbg_if slave modport (read/write/dump)
// Parameters: NB_DATA data width, NB_REG address width (2**NB_REG registers),
//   ZERO_REG hardwires register 0, BYPASS forwards same-cycle write data.
module register_file_dbg
  import regfile_pkg::*;
#(
  parameter int NB_DATA  = NB_DATA_DEF,
  parameter int NB_REG   = NB_REG_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  register_file_dbg_if.slave  bus
);

  localparam int NREGS = 2**NB_REG;

  logic [NB_DATA-1:0] regs_q [NREGS];
  logic [NB_DATA-1:0] regs_d [NREGS];
  logic               wr_en;
  logic [NB_DATA-1:0] rd_data1;
  logic [NB_DATA-1:0] rd_data2;
  logic               dump_valid;
  logic [NB_REG-1:0]  dump_idx;

  // Writes to register 0 are dropped when it is hardwired.
  assign wr_en = bus.i_write_enable && !(ZERO_REG && (bus.i_write_reg == '0));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.i_write_reg] = bus.i_write_data;
    end
  end

  // NOTE: the architectural state must read 0 after reset, so the whole array
  // is reset; this keeps it in flops rather than an inferred RAM macro.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Priority: hardwired zero beats bypass, bypass beats stored value.
  always_comb begin
    rd_data1 = regs_q[bus.i_read_reg1];
    if (BYPASS && bus.i_write_enable && (bus.i_read_reg1 == bus.i_write_reg)) begin
      rd_data1 = bus.i_write_data;
    end
    if (ZERO_REG && (bus.i_read_reg1 == '0)) begin
      rd_data1 = '0;
    end

    rd_data2 = regs_q[bus.i_read_reg2];
    if (BYPASS && bus.i_write_enable && (bus.i_read_reg2 == bus.i_write_reg)) begin
      rd_data2 = bus.i_write_data;
    end
    if (ZERO_REG && (bus.i_read_reg2 == '0)) begin
      rd_data2 = '0;
    end
  end

  assign bus.o_register1 = rd_data1;
  assign bus.o_register2 = rd_data2;

  register_dump_ctrl #(
    .NB_REG (NB_REG)
  ) u_dump_ctrl (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_dump_start (bus.i_dump_start),
    .i_dump_ready (bus.i_dump_ready),
    .o_dump_valid (dump_valid),
    .o_dump_done  (bus.o_dump_done),
    .o_busy       (bus.o_busy),
    .o_dump_idx   (dump_idx)
  );

  assign bus.o_dump_valid = dump_valid;
  assign bus.o_dump_idx   = dump_idx;
  // Stored contents only: a write during a stalled beat shows up here in the
  // following cycle, which is the value captured at the accepting edge.
  assign bus.o_dump_data  = dump_valid ? regs_q[dump_idx] : '0;

endmodule
